// File: rtl/window_33.sv
// Horizontal 3x3 window assembler: delays incoming 3-row columns by one and two pixels
// and emits {col x+1, col x, col x-1} per pixel/channel. WINDOW33_ZERO_PAD_EN selects same-padding.
module window_33 #(
  parameter int SIZE    = 28,
  parameter int CHANNEL = 128,
  parameter int LEN     = 3
) (
  input  logic               i_sclk,
  input  logic               i_vsync,
  input  logic               i_hsync,
  input  logic               i_reuse,
  input  logic               i_valid,
  input  logic [2*LEN-1:0]   i_tdata,
  output logic               o_vsync_w,
  output logic               o_hsync_w,
  output logic               o_reuse_w,
  output logic               o_valid_w,
  output logic [6*LEN-1:0]   o_tdata_w,
  output logic               o_error
);

`ifdef WINDOW33_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  localparam int CW  = 2*LEN;
  localparam int CHW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam int PW  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CHW-1:0] CH_LAST   = CHW'(CHANNEL-1);
  localparam logic [PW-1:0]  PX_LASTIN = PW'(SIZE-2);
  localparam logic [PW-1:0]  PX_END    = PW'(SIZE-1);
  // Pixel index of the first emitted window; also where loading stops.
  localparam logic [PW-1:0]  FIRST_PX  = PAD ? PW'(0) : PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t                   state_q, state_d;
  logic [CHW-1:0]           ch_q, ch_d;
  logic [PW-1:0]            px_q, px_d;
  logic [CHANNEL-1:0][CW-1:0] d1_q, d2_q;
  logic                     err_q, err_d;
  logic                     reuse_q, reuse_d;
  logic                     pend_q, pend_d;
  logic                     pend_reuse_q, pend_reuse_d;
  logic                     shift, clr_d1, win_vld, win_hs;
  logic [CW-1:0]            col_in, col_left;
  logic                     ch_last;

  assign ch_last  = (ch_q == CH_LAST);
  assign col_left = (PAD && px_q == '0) ? '0 : d2_q[CHANNEL-1];

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    px_d         = px_q;
    err_d        = err_q;
    reuse_d      = reuse_q;
    pend_d       = pend_q;
    pend_reuse_d = pend_reuse_q;
    shift        = 1'b0;
    clr_d1       = 1'b0;
    win_vld      = 1'b0;
    win_hs       = 1'b0;
    col_in       = i_tdata;
    case (state_q)
      S_IDLE: begin
        if (i_valid) err_d = 1'b1;
        if (i_hsync) begin
          state_d = S_FILL;
          reuse_d = i_reuse;
          ch_d    = '0;
          px_d    = '0;
        end
      end
      S_FILL, S_RUN: begin
        if (i_hsync) begin
          err_d   = 1'b1;
          state_d = S_FILL;
          reuse_d = i_reuse;
          ch_d    = '0;
          px_d    = '0;
          clr_d1  = 1'b1;
        end else if (i_valid) begin
          shift = 1'b1;
          if (state_q == S_RUN) begin
            win_vld = 1'b1;
            win_hs  = (px_q == FIRST_PX) && (ch_q == '0);
          end
          if (!ch_last) begin
            ch_d = ch_q + 1'b1;
          end else begin
            ch_d = '0;
            if (state_q == S_FILL) begin
              if (px_q == FIRST_PX) state_d = S_RUN;
              else                  px_d    = px_q + 1'b1;
            end else if (px_q == PX_LASTIN) begin
              state_d = PAD ? S_FLUSH : S_IDLE;
              px_d    = PAD ? PX_END : '0;
            end else begin
              px_d = px_q + 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        // Right padding: last pixel is output against a zero column.
        shift   = 1'b1;
        col_in  = '0;
        win_vld = 1'b1;
        if (i_valid) err_d = 1'b1;
        if (i_hsync) begin
          err_d        = 1'b1;
          pend_d       = 1'b1;
          pend_reuse_d = i_reuse;
        end
        if (!ch_last) begin
          ch_d = ch_q + 1'b1;
        end else begin
          ch_d = '0;
          px_d = '0;
          if (pend_q || i_hsync) begin
            state_d = S_FILL;
            reuse_d = i_hsync ? i_reuse : pend_reuse_q;
            pend_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sclk) begin
    o_vsync_w <= i_vsync;
    if (i_vsync) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      px_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      err_q        <= 1'b0;
      reuse_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_reuse_q <= 1'b0;
      o_hsync_w    <= 1'b0;
      o_valid_w    <= 1'b0;
      o_tdata_w    <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      px_q         <= px_d;
      err_q        <= err_d;
      reuse_q      <= reuse_d;
      pend_q       <= pend_d;
      pend_reuse_q <= pend_reuse_d;
      if (clr_d1) begin
        d1_q <= '0;
      end else if (shift) begin
        d1_q <= {d1_q[CHANNEL-2:0], col_in};
        d2_q <= {d2_q[CHANNEL-2:0], d1_q[CHANNEL-1]};
      end
      o_hsync_w <= win_hs;
      o_valid_w <= win_vld;
      o_tdata_w <= win_vld ? {col_in, d1_q[CHANNEL-1], col_left} : '0;
    end
  end

  assign o_reuse_w = reuse_q;
  assign o_error   = err_q;

endmodule

// File: tb/tb_window_33.sv
// Scoreboard bench for window_33 (SIZE=4, CHANNEL=2): driver pushes expected windows
// computed from column arrays, a negedge monitor pops and compares.
module tb_window_33;
  localparam int SIZE = 4;
  localparam int CH   = 2;
`ifdef WINDOW33_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int FIRST_PX = PAD ? 0 : 1;
  localparam int LAST_PX  = PAD ? SIZE-1 : SIZE-2;

  logic clk = 1'b0;
  logic i_vsync, i_hsync, i_reuse, i_valid;
  logic [5:0]  i_tdata;
  logic o_vsync_w, o_hsync_w, o_reuse_w, o_valid_w, o_error;
  logic [17:0] o_tdata_w;

  window_33 #(.SIZE(SIZE), .CHANNEL(CH), .LEN(3)) dut (
    .i_sclk(clk), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_reuse(i_reuse),
    .i_valid(i_valid), .i_tdata(i_tdata), .o_vsync_w(o_vsync_w),
    .o_hsync_w(o_hsync_w), .o_reuse_w(o_reuse_w), .o_valid_w(o_valid_w),
    .o_tdata_w(o_tdata_w), .o_error(o_error));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [17:0] d;
    logic        hs;
    logic        ru;
    int          tag;
  } win_t;

  win_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [5:0] cols [SIZE][CH];
  logic cur_reuse = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference window: neighbours of pixel p, zero outside the line.
  task automatic push_win(input int p, input int c, input int tag);
    win_t w;
    logic [5:0] l, r;
    l = (p == 0) ? 6'h0 : cols[p-1][c];
    r = (p == SIZE-1) ? 6'h0 : cols[p+1][c];
    w.d   = {r, cols[p][c], l};
    w.hs  = (p == FIRST_PX) && (c == 0);
    w.ru  = cur_reuse;
    w.tag = tag;
    q.push_back(w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0; i_tdata = '0;
    end
  endtask

  task automatic pulse_hsync(input logic rr);
    @(negedge clk);
    i_valid = 1'b0; i_hsync = 1'b1; i_reuse = rr;
    @(negedge clk);
    i_hsync = 1'b0;
    cur_reuse = rr;
  endtask

  // abort_at: beat index where the line is cut; kind 1 = hsync restart, 2 = vsync.
  task automatic send_line(input bit do_hs, input logic rr, input int gap, input bit rnd,
                           input int abort_at, input int kind);
    int last_tag;
    last_tag = 0;
    for (int p = 0; p < SIZE; p++)
      for (int c = 0; c < CH; c++)
        cols[p][c] = rnd ? 6'($urandom) : 6'(1 + p*2 + c);
    if (do_hs) pulse_hsync(rr);
    for (int k = 0; k < SIZE*CH; k++) begin
      int p, c;
      p = k / CH;
      c = k % CH;
      if (k == abort_at) begin
        @(negedge clk);
        i_valid = 1'b0;
        if (kind == 1) begin
          i_hsync = 1'b1; i_reuse = ~rr;
          @(negedge clk);
          i_hsync = 1'b0;
          cur_reuse = ~rr;
          chk("error after hsync restart", o_error, 1);
        end else begin
          i_vsync = 1'b1;
          @(negedge clk);
          i_vsync = 1'b0;
          chk("vsync out", o_vsync_w, 1);
          chk("vsync clears outputs", {o_hsync_w, o_reuse_w, o_valid_w, o_tdata_w, o_error}, 0);
        end
        return;
      end
      @(negedge clk);
      i_valid = 1'b1; i_tdata = cols[p][c];
      last_tag = cyc + 1;
      if (p >= FIRST_PX + 1 && p - 1 <= LAST_PX) push_win(p - 1, c, last_tag);
      if (gap > 0 && k != SIZE*CH-1) idle(gap);
    end
    if (PAD)
      for (int c = 0; c < CH; c++) push_win(SIZE-1, c, last_tag + 1 + c);
  endtask

  always @(negedge clk) begin
    if (o_valid_w) begin
      if (q.size() == 0) begin
        chk("spurious window", 1, 0);
      end else begin
        win_t e;
        e = q.pop_front();
        chk("window {hs,reuse,data}", {o_hsync_w, o_reuse_w, o_tdata_w}, {e.hs, e.ru, e.d});
        chk("window latency", cyc, e.tag);
      end
    end else if (o_hsync_w) begin
      chk("hsync without valid", 1, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d windows pending", q.size());
    $fatal(1);
  end

  initial begin
    i_vsync = 1'b1; i_hsync = 1'b0; i_reuse = 1'b0; i_valid = 1'b0; i_tdata = '0;
    repeat (2) @(negedge clk);
    chk("reset vsync", o_vsync_w, 1);
    chk("reset outputs", {o_hsync_w, o_reuse_w, o_valid_w, o_tdata_w, o_error}, 0);
    idle(2);

    send_line(1, 1'b1, 0, 0, -1, 0);
    idle(CH + 3);
    chk("no error after clean line", o_error, 0);

    send_line(1, 1'($urandom), 1, 1, -1, 0);
    idle(CH + 3);
    chk("no error after gapped line", o_error, 0);

    // Stray beat in IDLE
    @(negedge clk);
    i_valid = 1'b1; i_tdata = 6'h2a;
    idle(2);
    chk("error on idle beat", o_error, 1);

    send_line(1, 1'b1, 0, 1, 3, 2);
    idle(2);
    send_line(1, 1'($urandom), 0, 1, -1, 0);
    idle(CH + 3);
    chk("no error after vsync recovery", o_error, 0);

    send_line(1, 1'b0, 0, 1, 5, 1);
    send_line(0, cur_reuse, 0, 1, -1, 0);
    idle(CH + 3);
    chk("error sticky after restart", o_error, 1);

    idle(1);
    i_vsync = 1'b1;
    idle(1);
    chk("error cleared by vsync", o_error, 0);
    idle(1);

    // hsync one cycle after the last beat
    send_line(1, 1'b1, 0, 1, -1, 0);
    @(negedge clk);
    i_valid = 1'b0; i_hsync = 1'b1; i_reuse = 1'b0;
    @(negedge clk);
    i_hsync = 1'b0;
    chk("error on hsync in flush", o_error, PAD);
    idle(CH + 1);
    cur_reuse = 1'b0;
    send_line(0, 1'b0, 1, 1, -1, 0);
    idle(CH + 4);

    chk("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
